// File: rtl/pixel_stream_source.sv
// pixel_stream_source
//   Raster-order pixel producer: reads one WIDTH x HEIGHT 8-bit frame from a
//   synchronous-read RAM and presents it as a pixel / pix_en stream with
//   row/col position and sof/eol/eof markers. A 2-entry skid buffer absorbs
//   downstream stalls so no pixel is lost or repeated.
//   Build option: define PIX_SRC_FLUSH_EN to append FLUSH_PIXELS zero pixels
//   after the last image pixel (drains the downstream line buffers).
module pixel_stream_source #(
  parameter int WIDTH        = 400,
  parameter int HEIGHT       = 300,
  parameter int ADDR_W       = 17,
  parameter int FLUSH_PIXELS = 802
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] frame_base,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  input  logic              pix_ready,
  output logic [7:0]        pix_out,
  output logic              pix_en,
  output logic [15:0]       col,
  output logic [15:0]       row,
  output logic              sof,
  output logic              eol,
  output logic              eof,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(WIDTH * HEIGHT - 1);
  localparam logic [15:0]       COL_LAST = 16'(WIDTH - 1);
  localparam logic [15:0]       ROW_LAST = 16'(HEIGHT - 1);

  // A zero-length flush is not a meaningful configuration.
  if (FLUSH_PIXELS < 1) begin : g_flush_pixels_check
    $error("FLUSH_PIXELS must be at least 1");
  end

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_DRAIN = 3'd2,
`ifdef PIX_SRC_FLUSH_EN
    ST_FLUSH = 3'd4,
`endif
    ST_FIN   = 3'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] base;        // frame_base captured at accepted start
  logic [ADDR_W-1:0] rd_idx;      // linear index of the next read
  logic              rd_valid;    // read issued last cycle: mem_rdata valid now
  logic [1:0]        skid_cnt;    // stored skid entries (0..2)
  logic [7:0]        slot0;       // skid head
  logic [7:0]        slot1;       // skid second entry
  logic [2:0]        occupancy;
  logic              has_data;
  logic              img_phase;
  logic              flush_phase;
  logic              img_xfer;
  logic              start_ok;
  logic [7:0]        head;
`ifdef PIX_SRC_FLUSH_EN
  localparam logic [15:0] FLUSH_LAST = 16'(FLUSH_PIXELS - 1);
  logic [15:0]       flush_cnt;
`endif

  assign start_ok  = (state == ST_IDLE) && start;
  assign img_phase = (state == ST_READ) || (state == ST_DRAIN);
`ifdef PIX_SRC_FLUSH_EN
  assign flush_phase = (state == ST_FLUSH);
`else
  assign flush_phase = 1'b0;
`endif

  // Skid/read bookkeeping and the visible head pixel (stored entry first,
  // otherwise the read data arriving this cycle).
  always_comb begin
    occupancy = {1'b0, skid_cnt} + {2'b00, rd_valid};
    has_data  = (skid_cnt != 2'd0) || rd_valid;
    if (skid_cnt != 2'd0) begin
      head = slot0;
    end else if (rd_valid) begin
      head = mem_rdata;
    end else begin
      head = 8'h00;
    end
  end

  // Stream, read and status outputs derived from state and skid contents.
  always_comb begin
    mem_rd_en = (state == ST_READ) && (occupancy < 3'd2);
    mem_addr  = base + rd_idx;
    img_xfer  = img_phase && has_data && pix_ready;
    pix_en    = img_xfer || (flush_phase && pix_ready);
    pix_out   = img_phase ? head : 8'h00;
    sof       = img_xfer && (row == 16'd0) && (col == 16'd0);
    eol       = img_xfer && (col == COL_LAST);
    eof       = img_xfer && (col == COL_LAST) && (row == ROW_LAST);
    busy      = (state != ST_IDLE) && (state != ST_FIN);
    done      = (state == ST_FIN);
  end

  // Next-state logic for the frame sequencer.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_READ;
        else       state_nxt = ST_IDLE;
      end
      ST_READ: begin
        if (mem_rd_en && (rd_idx == LAST_IDX)) state_nxt = ST_DRAIN;
        else                                   state_nxt = ST_READ;
      end
      ST_DRAIN: begin
`ifdef PIX_SRC_FLUSH_EN
        if (eof) state_nxt = ST_FLUSH;
        else     state_nxt = ST_DRAIN;
`else
        if (eof) state_nxt = ST_FIN;
        else     state_nxt = ST_DRAIN;
`endif
      end
`ifdef PIX_SRC_FLUSH_EN
      ST_FLUSH: begin
        if (pix_en && (flush_cnt == FLUSH_LAST)) state_nxt = ST_FIN;
        else                                     state_nxt = ST_FLUSH;
      end
`endif
      ST_FIN:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Read address generation and output position counters.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      base     <= '0;
      rd_idx   <= '0;
      rd_valid <= 1'b0;
      col      <= 16'd0;
      row      <= 16'd0;
    end else begin
      rd_valid <= mem_rd_en;
      if (start_ok) begin
        base   <= frame_base;
        rd_idx <= '0;
        col    <= 16'd0;
        row    <= 16'd0;
      end else begin
        if (mem_rd_en) rd_idx <= rd_idx + {{(ADDR_W-1){1'b0}}, 1'b1};
        // Position advances per image transfer and holds on the last pixel.
        if (img_xfer && !eof) begin
          if (col == COL_LAST) begin
            col <= 16'd0;
            row <= row + 16'd1;
          end else begin
            col <= col + 16'd1;
          end
        end
      end
    end
  end

  // Two-entry skid buffer: arriving read data bypasses to the output when
  // the buffer is empty and the consumer takes it, otherwise it is stored.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      skid_cnt <= 2'd0;
      slot0    <= 8'h00;
      slot1    <= 8'h00;
    end else begin
      case (skid_cnt)
        2'd0: begin
          if (rd_valid && !img_xfer) begin
            slot0    <= mem_rdata;
            skid_cnt <= 2'd1;
          end
        end
        2'd1: begin
          if (img_xfer) begin
            if (rd_valid) slot0 <= mem_rdata;
            else          skid_cnt <= 2'd0;
          end else if (rd_valid) begin
            slot1    <= mem_rdata;
            skid_cnt <= 2'd2;
          end
        end
        2'd2: begin
          if (img_xfer) begin
            slot0 <= slot1;
            if (rd_valid) slot1 <= mem_rdata;
            else          skid_cnt <= 2'd1;
          end
        end
        default: skid_cnt <= 2'd0;
      endcase
    end
  end

`ifdef PIX_SRC_FLUSH_EN
  // Count zero pixels delivered during the flush.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      flush_cnt <= 16'd0;
    end else if (start_ok) begin
      flush_cnt <= 16'd0;
    end else if (flush_phase && pix_en) begin
      flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif

endmodule
